// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_fsm
// Purpose  : Main control FSM for the single-memory multicycle MIPS-subset
//            datapath. Decodes IR[31:26] and sequences the datapath strobes
//            through FETCH, DECODE, execute and writeback states, with an
//            optional memory-ready wait and configurable illegal-opcode trap.
// Ports    : clk, rst_n (async, active-low)
//            Opcode[5:0]  - IR[31:26], stable from DECODE to the next FETCH
//            MemReady     - memory access completes this cycle
//            PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
//            RegWrite, ALUSrcA, Branch, BranchNe, ImmZext, Illegal - strobes
//            ALUSrcB[1:0], PCSrc[1:0], ALUOp[ALUOP_W-1:0] - selects
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_fsm #(
  parameter int ALUOP_W   = 3,
  parameter bit MEM_WAIT  = 1'b1,
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Opcode,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               Branch,
  output logic               BranchNe,
  output logic               ImmZext,
  output logic               Illegal,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [ALUOP_W-1:0] c_ALU_ADD   = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] c_ALU_SUB   = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] c_ALU_FUNCT = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] c_ALU_AND   = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] c_ALU_OR    = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] c_ALU_SLT   = ALUOP_W'(3'd5);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_ready;

  // Without the wait handshake every memory access is taken as complete.
  assign w_ready = MEM_WAIT ? MemReady : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = S_FETCH;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    ImmZext  = 1'b0;
    Illegal  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUOp    = c_ALU_ADD;

    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC and IR load only in the cycle the instruction word arrives.
        IRWrite = w_ready;
        PCWrite = w_ready;
        w_next  = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;                 // branch target precompute
        case (Opcode)
          c_OP_RTYPE:                               w_next = S_RTEXEC;
          c_OP_LW, c_OP_SW:                         w_next = S_MEMADR;
          c_OP_ADDI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI: w_next = S_IEXEC;
          c_OP_BEQ, c_OP_BNE:                       w_next = S_BRANCH;
          c_OP_J:                                   w_next = S_JUMP;
          default:                                  w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = w_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = c_ALU_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_next   = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (Opcode)
          c_OP_SLTI: ALUOp = c_ALU_SLT;
          c_OP_ANDI: begin
            ALUOp   = c_ALU_AND;
            ImmZext = 1'b1;
          end
          c_OP_ORI: begin
            ALUOp   = c_ALU_OR;
            ImmZext = 1'b1;
          end
          default:   ALUOp = c_ALU_ADD;
        endcase
        w_next = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = c_ALU_SUB;
        PCSrc    = 2'b01;
        Branch   = (Opcode == c_OP_BEQ);
        BranchNe = (Opcode == c_OP_BNE);
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        w_next  = S_FETCH;
      end
      S_TRAP: begin
        Illegal = 1'b1;
        w_next  = TRAP_HALT ? S_TRAP : S_FETCH;
      end
      default: begin
        // Unused encodings: all outputs stay at their zero defaults.
        w_next = S_FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_main_fsm
// Purpose  : Self-checking bench for multicycle_main_fsm. Two instances:
//            u0 (ALUOP_W=3, MEM_WAIT=1, TRAP_HALT=1) and
//            u1 (ALUOP_W=4, MEM_WAIT=0, TRAP_HALT=0).
//            Directed literal checks followed by random instruction streams
//            compared every cycle against a per-instruction step-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_fsm;

  typedef struct packed {
    logic       pcw, iord, mr, mw, irw, rd, m2r, rw, asa, br, bne, iz, ill;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
  } ov_t;

  typedef struct {
    ov_t v;
    bit  waits;   // advances only when memory is ready
    bit  fetch;   // PCWrite/IRWrite follow memory ready
    bit  ign;     // opcode is a don't-care here
    bit  halt;    // never advances (halting trap)
  } step_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n;
  logic [1:0] mready;
  logic [5:0] opc [2];

  always #5 clk = ~clk;

  logic pcw0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, asa0, br0, bne0, iz0, ill0;
  logic [1:0] srcb0, pcsrc0;
  logic [2:0] aluop0;
  logic pcw1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, br1, bne1, iz1, ill1;
  logic [1:0] srcb1, pcsrc1;
  logic [3:0] aluop1;

  multicycle_main_fsm #(.ALUOP_W(3), .MEM_WAIT(1'b1), .TRAP_HALT(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .Opcode(opc[0]), .MemReady(mready[0]),
    .PCWrite(pcw0), .IorD(iord0), .MemRead(mr0), .MemWrite(mw0), .IRWrite(irw0),
    .RegDst(rd0), .MemtoReg(m2r0), .RegWrite(rw0), .ALUSrcA(asa0),
    .Branch(br0), .BranchNe(bne0), .ImmZext(iz0), .Illegal(ill0),
    .ALUSrcB(srcb0), .PCSrc(pcsrc0), .ALUOp(aluop0)
  );

  multicycle_main_fsm #(.ALUOP_W(4), .MEM_WAIT(1'b0), .TRAP_HALT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .Opcode(opc[1]), .MemReady(mready[1]),
    .PCWrite(pcw1), .IorD(iord1), .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1),
    .RegDst(rd1), .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(asa1),
    .Branch(br1), .BranchNe(bne1), .ImmZext(iz1), .Illegal(ill1),
    .ALUSrcB(srcb1), .PCSrc(pcsrc1), .ALUOp(aluop1)
  );

  ov_t o0, o1;
  assign o0 = {pcw0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, asa0, br0, bne0, iz0, ill0,
               srcb0, pcsrc0, 1'b0, aluop0};
  assign o1 = {pcw1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, br1, bne1, iz1, ill1,
               srcb1, pcsrc1, aluop1};

  int n_cmp = 0;
  int n_bad = 0;

  step_t      q[$];
  int         sidx;
  logic [5:0] cur_op;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_vec(input int k, input string nm, input ov_t e);
    ov_t a;
    a = (k == 0) ? o0 : o1;
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s inst%0d op=%0h t=%0t: got %h expected %h", nm, k, cur_op, $time, a, e);
    end
  endtask

  function automatic step_t mk(input ov_t v, input bit w, input bit f, input bit ig, input bit h);
    step_t s;
    s.v = v; s.waits = w; s.fetch = f; s.ign = ig; s.halt = h;
    return s;
  endfunction

  // Build the list of per-cycle output expectations for one instruction.
  function automatic void new_instr(input int k);
    ov_t        v;
    logic [5:0] legal [10];
    legal = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    if ($urandom_range(0, 9) < 8) cur_op = legal[$urandom_range(0, 9)];
    else                          cur_op = 6'($urandom);
    q.delete();
    sidx = 0;
    v = '0; v.mr = 1'b1; v.srcb = 2'b01;
    q.push_back(mk(v, 1'b1, 1'b1, 1'b1, 1'b0));
    v = '0; v.srcb = 2'b11;
    q.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
    case (cur_op)
      6'h23, 6'h2B: begin
        v = '0; v.asa = 1'b1; v.srcb = 2'b10;
        q.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
        if (cur_op == 6'h23) begin
          v = '0; v.mr = 1'b1; v.iord = 1'b1;
          q.push_back(mk(v, 1'b1, 1'b0, 1'b1, 1'b0));
          v = '0; v.rw = 1'b1; v.m2r = 1'b1;
          q.push_back(mk(v, 1'b0, 1'b0, 1'b1, 1'b0));
        end else begin
          v = '0; v.mw = 1'b1; v.iord = 1'b1;
          q.push_back(mk(v, 1'b1, 1'b0, 1'b1, 1'b0));
        end
      end
      6'h00: begin
        v = '0; v.asa = 1'b1; v.aluop = 4'd2;
        q.push_back(mk(v, 1'b0, 1'b0, 1'b1, 1'b0));
        v = '0; v.rw = 1'b1; v.rd = 1'b1;
        q.push_back(mk(v, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        v = '0; v.asa = 1'b1; v.srcb = 2'b10;
        v.aluop = (cur_op == 6'h0A) ? 4'd5 : (cur_op == 6'h0C) ? 4'd3 :
                  (cur_op == 6'h0D) ? 4'd4 : 4'd0;
        v.iz = (cur_op == 6'h0C) || (cur_op == 6'h0D);
        q.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
        v = '0; v.rw = 1'b1;
        q.push_back(mk(v, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      6'h04, 6'h05: begin
        v = '0; v.asa = 1'b1; v.aluop = 4'd1; v.pcsrc = 2'b01;
        v.br = (cur_op == 6'h04); v.bne = (cur_op == 6'h05);
        q.push_back(mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      6'h02: begin
        v = '0; v.pcw = 1'b1; v.pcsrc = 2'b10;
        q.push_back(mk(v, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      default: begin
        v = '0; v.ill = 1'b1;
        q.push_back(mk(v, 1'b0, 1'b0, 1'b1, k == 0));
      end
    endcase
  endfunction

  // Random instruction stream on instance k with random MemReady and resets.
  task automatic run_rand(input int k, input int ncyc);
    step_t s;
    ov_t   e;
    bit    effr;
    bit    do_rst;
    int    trapcnt;
    trapcnt   = 0;
    rst_n[k]  = 1'b0;
    mready[k] = 1'b1;
    cyc();
    rst_n[k] = 1'b1;
    new_instr(k);
    for (int c = 0; c < ncyc; c++) begin
      s = q[sidx];
      mready[k] = ($urandom_range(0, 9) < 7);
      opc[k]    = s.ign ? 6'($urandom) : cur_op;
      effr      = (k == 0) ? mready[k] : 1'b1;
      e = s.v;
      if (s.fetch) begin
        e.pcw = effr;
        e.irw = effr;
      end
      do_rst = (s.halt && trapcnt >= 12) || ($urandom_range(0, 59) == 0);
      if (do_rst) begin
        #1 rst_n[k] = 1'b0;
        #2;
        e = '0; e.mr = 1'b1; e.srcb = 2'b01; e.pcw = effr; e.irw = effr;
        cmp_vec(k, "reset_vec", e);
        cyc();
        rst_n[k] = 1'b1;
        trapcnt  = 0;
        new_instr(k);
      end else begin
        #3;
        cmp_vec(k, "step_vec", e);
        cyc();
        if (s.halt) trapcnt++;
        else if (!s.waits || effr) begin
          sidx++;
          if (sidx == q.size()) new_instr(k);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 2'b00;
    mready    = 2'b11;
    opc[0]    = 6'h00;
    opc[1]    = 6'h00;
    cur_op    = 6'h00;
    cyc();
    cyc();

    // Reset state shows FETCH values, PCWrite follows MemReady combinationally.
    #3;
    chk("rst_memread", {7'd0, mr0}, 8'd1);
    chk("rst_alusrcb", {6'd0, srcb0}, 8'd1);
    chk("rst_pcwrite_ready", {6'd0, pcw0, irw0}, 8'd3);
    chk("rst_illegal_memwrite", {6'd0, ill0, mw0}, 8'd0);
    mready[0] = 1'b0;
    #1;
    chk("rst_pcwrite_notready", {6'd0, pcw0, irw0}, 8'd0);
    cyc();

    // sw with 3 not-ready cycles in MEMWR: FETCH again on cycle 8.
    rst_n[0] = 1'b1; opc[0] = 6'h2B; mready[0] = 1'b1;
    #3 chk("sw_fetch_pcw", {7'd0, pcw0}, 8'd1);
    cyc();
    #3 chk("sw_decode_srcb", {6'd0, srcb0}, 8'd3);
    cyc();
    #3 chk("sw_memadr", {5'd0, asa0, srcb0}, 8'b110);
    cyc();
    for (int i = 0; i < 4; i++) begin
      mready[0] = (i == 3);
      #3 chk("sw_memwrite_hold", {6'd0, mw0, iord0}, 8'd3);
      cyc();
    end
    // Fetch waits 2 cycles then a single strobe pulse.
    opc[0] = 6'h05; mready[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3 chk("fetch_wait_strobes", {5'd0, mw0, pcw0, irw0}, 8'd0);
      cyc();
    end
    mready[0] = 1'b1;
    #3 chk("fetch_pulse", {6'd0, pcw0, irw0}, 8'd3);
    cyc();
    #3 chk("decode_no_strobe", {6'd0, pcw0, irw0}, 8'd0);
    cyc();
    #3 chk("bne_flags", {6'd0, bne0, br0}, 8'b10);
    chk("bne_aluop", {5'd0, aluop0}, 8'd1);
    chk("bne_pcsrc", {6'd0, pcsrc0}, 8'd1);
    cyc();
    // andi
    opc[0] = 6'h0C;
    cyc();
    cyc();
    #3 chk("andi_aluop", {5'd0, aluop0}, 8'd3);
    chk("andi_zext", {7'd0, iz0}, 8'd1);
    cyc();
    #3 chk("andi_wb", {5'd0, rw0, rd0, m2r0}, 8'b100);
    cyc();
    // lw: RegWrite with MemtoReg only in cycle 5
    opc[0] = 6'h23;
    for (int i = 1; i <= 5; i++) begin
      #3 chk("lw_regwrite", {6'd0, rw0, m2r0}, (i == 5) ? 8'd3 : 8'd0);
      cyc();
    end
    // sw interrupted by reset while waiting in MEMWR
    opc[0] = 6'h2B;
    cyc();
    cyc();
    cyc();
    mready[0] = 1'b0;
    #3 chk("memwr_before_rst", {7'd0, mw0}, 8'd1);
    rst_n[0] = 1'b0;
    #1 chk("memwr_async_rst", {5'd0, mw0, mr0, ill0}, 8'b010);
    cyc();
    rst_n[0] = 1'b1; mready[0] = 1'b1; opc[0] = 6'h3F;
    cyc();
    cyc();
    // halting trap
    for (int i = 0; i < 12; i++) begin
      opc[0] = 6'($urandom);
      #3 chk("trap_halt_illegal", {7'd0, ill0}, 8'd1);
      cyc();
    end
    rst_n[0] = 1'b0;
    #3 chk("trap_released_by_rst", {6'd0, ill0, mr0}, 8'd1);
    cyc();

    // u1: one-cycle trap, MemReady ignored, ALUOp zero-extended
    rst_n[1] = 1'b1; opc[1] = 6'h3F; mready[1] = 1'b0;
    #3 chk("nowait_fetch_pcw", {6'd0, pcw1, irw1}, 8'd3);
    cyc();
    #3 chk("nowait_decode_aluop", {4'd0, aluop1}, 8'd0);
    cyc();
    #3 chk("trap_pulse", {7'd0, ill1}, 8'd1);
    cyc();
    #3 chk("trap_to_fetch", {6'd0, ill1, mr1}, 8'd1);
    cyc();

    run_rand(0, 1500);
    rst_n[0] = 1'b0;
    run_rand(1, 1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
